// File: rtl/param_serial_div_pkg.sv
// Shared definitions for the parametrised serial divider: FSM state
// encodings and the start/ready handshake constants.
package param_serial_div_pkg;

  typedef enum logic [2:0] {
    S_FREE = 3'd0,
    S_ZERO = 3'd1,
    S_ON   = 3'd2,
    S_FIX  = 3'd3,
    S_END  = 3'd4
  } div_state_e;

  localparam logic DivStart    = 1'b1;
  localparam logic DivStop     = 1'b0;
  localparam logic ResReady    = 1'b1;
  localparam logic ResNotReady = 1'b0;

endpackage

// File: rtl/param_serial_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor and keep the difference unless the subtraction borrowed.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so a non-borrowing difference always fits in WIDTH bits
  // and the MSB of the (WIDTH+1)-bit difference is exactly the borrow.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/param_serial_div.sv
// Multi-cycle signed/unsigned restoring divider resolving UNROLL quotient
// bits per cycle; result is {remainder, quotient}.
module param_serial_div
  import param_serial_div_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               busy_o
);

  localparam int unsigned K  = WIDTH / UNROLL;
  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  div_state_e       state;
  logic             signed_q;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] op1_raw;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] rem_c [UNROLL+1];
  logic [UNROLL-1:0] q_c;
  logic [WIDTH-1:0] quot_next;

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  // The quotient register doubles as the dividend shifter: step g consumes
  // bit WIDTH-1-g and the new quotient bits enter at the bottom, MSB first.
  assign rem_c[0] = rem;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_in (rem_c[g]),
      .dvd_bit(quot[WIDTH-1-g]),
      .divisor(dvs),
      .rem_out(rem_c[g+1]),
      .q_bit  (q_c[g])
    );
  end

  always_comb begin
    quot_next = quot;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      quot_next = {quot_next[WIDTH-2:0], q_c[j]};
    end
  end

  assign busy_o = (state != S_FREE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FREE;
      ready_o    <= ResNotReady;
      div_zero_o <= 1'b0;
      result_o   <= '0;
    end else begin
      unique case (state)
        S_FREE: begin
          if (start_i == DivStart && !annul_i) begin
            signed_q <= signed_div_i;
            sign1    <= opdata1_i[WIDTH-1];
            sign2    <= opdata2_i[WIDTH-1];
            op1_raw  <= opdata1_i;
            dvs      <= mag2;
            quot     <= mag1;
            rem      <= '0;
            cnt      <= '0;
            state    <= (opdata2_i == '0) ? S_ZERO : S_ON;
          end
        end
        S_ZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            quot  <= '1;
            rem   <= op1_raw;
            state <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            quot <= quot_next;
            rem  <= rem_c[UNROLL];
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            if (signed_q && (sign1 ^ sign2)) quot <= -quot;
            if (signed_q && sign1)           rem  <= -rem;
            state <= S_END;
          end
        end
        S_END: begin
          if (start_i == DivStop) begin
            state      <= S_FREE;
            ready_o    <= ResNotReady;
            div_zero_o <= 1'b0;
            result_o   <= '0;
          end else begin
            ready_o    <= ResReady;
            div_zero_o <= (dvs == '0);
            result_o   <= {rem, quot};
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_div.sv
// Directed bench for param_serial_div: a 32-bit/UNROLL=1 instance and a
// 16-bit/UNROLL=4 instance driven from hand-computed vectors.
module tb_param_serial_div;

  logic        clk = 1'b0;
  logic        rst;

  logic        sg32, start32, annul32;
  logic [31:0] op1_32, op2_32;
  logic [63:0] res32;
  logic        rdy32, dz32, busy32;

  logic        sg16, start16, annul16;
  logic [15:0] op1_16, op2_16;
  logic [31:0] res16;
  logic        rdy16, dz16, busy16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_serial_div #(.WIDTH(32), .UNROLL(1)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(op1_32),
    .opdata2_i(op2_32), .start_i(start32), .annul_i(annul32),
    .result_o(res32), .ready_o(rdy32), .div_zero_o(dz32), .busy_o(busy32)
  );

  param_serial_div #(.WIDTH(16), .UNROLL(4)) dut16 (
    .clk(clk), .rst(rst), .signed_div_i(sg16), .opdata1_i(op1_16),
    .opdata2_i(op2_16), .start_i(start16), .annul_i(annul16),
    .result_o(res16), .ready_o(rdy16), .div_zero_o(dz16), .busy_o(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept, count edges until ready_o, check result, hold one more cycle,
  // then release start and check the return to FREE.
  task automatic div32(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz, input int elat);
    int lat;
    @(negedge clk);
    sg32 = s; op1_32 = a; op2_32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy"}, {63'd0, busy32}, 64'd1);
    lat = 0;
    while (!rdy32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " result"}, res32, {er, eq});
    check({tag, " dz"}, {63'd0, dz32}, {63'd0, edz});
    @(negedge clk); annul32 = 1'b1;
    @(posedge clk); #1;
    check({tag, " held"}, {dz32, rdy32, res32[61:0]}, {edz, 1'b1, er[29:0], eq});
    @(negedge clk); annul32 = 1'b0; start32 = 1'b0;
    @(posedge clk); #1;
    check({tag, " exit"}, {busy32, rdy32, dz32, 61'd0} | res32, 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    sg32 = 0; start32 = 0; annul32 = 0; op1_32 = '0; op2_32 = '0;
    sg16 = 0; start16 = 0; annul16 = 0; op1_16 = '0; op2_16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", {busy32, rdy32, dz32, 61'd0} | res32, 64'd0);
    check("reset16", {busy16, rdy16, dz16, 29'd0, res16}, 64'd0);
    @(negedge clk); rst = 1'b0;

    div32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    div32("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    div32("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    div32("dz5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    div32("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    div32("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    div32("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);

    // Annul during ON cycle 10, then a fresh divide.
    @(negedge clk); sg32 = 0; op1_32 = 32'd50; op2_32 = 32'd4; start32 = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk); annul32 = 1'b1; start32 = 1'b0;
    @(posedge clk); #1;
    check("annul busy", {63'd0, busy32}, 64'd0);
    @(negedge clk); annul32 = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rdy32 || busy32) seen++; end
    check("annul quiet", 64'(seen), 64'd0);
    div32("u9_3a", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Reset during ON, then the same recovery.
    @(negedge clk); op1_32 = 32'd50; op2_32 = 32'd4; start32 = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1; start32 = 1'b0;
    @(posedge clk); #1;
    check("rst mid", {busy32, rdy32, dz32, 61'd0} | res32, 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rdy32 || busy32) seen++; end
    check("rst quiet", 64'(seen), 64'd0);
    div32("u9_3b", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // 16-bit, 4 bits per cycle; operands scrambled after accept.
    @(negedge clk); sg16 = 0; op1_16 = 16'd1000; op2_16 = 16'd33; start16 = 1'b1;
    @(posedge clk); #1;
    op1_16 = 16'hABCD; op2_16 = 16'd0; sg16 = 1'b1;
    lat = 0;
    while (!rdy16 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("w16 latency", 64'(lat), 64'd6);
    check("w16 result", {32'd0, res16}, {32'd0, 16'd10, 16'd30});
    check("w16 dz", {63'd0, dz16}, 64'd0);
    @(negedge clk); start16 = 1'b0;
    @(posedge clk); #1;
    check("w16 exit", {busy16, rdy16, dz16, 29'd0, res16}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_serial_div.md
PARAM_SERIAL_DIV -- requirements
Module: param_serial_div

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be even and >= 8.
REQ-002 Parameter UNROLL, default 1, quotient bits resolved per cycle; SHALL be 1, 2 or 4 and divide WIDTH.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 opdata1_i  input  WIDTH  dividend.
REQ-007 opdata2_i  input  WIDTH  divisor.
REQ-008 start_i  input  1  level request; held high until result consumed.
REQ-009 annul_i  input  1  abort the in-flight divide.
REQ-010 result_o  output  2*WIDTH  {remainder, quotient}.
REQ-011 ready_o  output  1  result_o valid.
REQ-012 div_zero_o  output  1  divisor was zero; valid while ready_o=1.
REQ-013 busy_o  output  1  high in every state except FREE.

Function
REQ-014 States: FREE, ZERO, ON, FIX, END.
REQ-015 Define K = WIDTH/UNROLL, the number of ON cycles.
REQ-016 FREE: start_i=1 and annul_i=0 at an edge (the accept edge) latches signed_div_i, both operands and the operand sign bits.
REQ-017 At the accept edge, the block SHALL go to ZERO if opdata2_i=0, else to ON.
REQ-018 Every later cycle SHALL use only the latched copies; operand inputs may change after the accept edge.
REQ-019 ON: restoring division on operand magnitudes. Each cycle performs UNROLL compare/subtract/shift steps and yields UNROLL quotient bits, MSB first.
REQ-020 Subtraction SHALL be (WIDTH+1)-bit unsigned; the borrow bit selects restore.
REQ-021 After K ON cycles the block SHALL enter FIX.
REQ-022 FIX: negate the quotient iff signed and the latched sign bits differ; negate the remainder iff signed and the dividend was negative. Then enter END.
REQ-023 ZERO: quotient SHALL be all-ones and remainder the latched opdata1; div_zero_o is set. Then enter END.
REQ-024 END: ready_o=1 and result_o stable from the first END cycle.
REQ-025 Latency: ready_o SHALL first read 1 exactly K+2 cycles after the accept edge (2 cycles for divide-by-zero).
REQ-026 END exit: start_i=0 at an edge gives FREE with ready_o=0, div_zero_o=0 and result_o=0 on the same edge; otherwise END is held indefinitely.
REQ-027 Annul: annul_i=1 in ZERO, ON or FIX gives FREE on the next edge; ready_o never rises for that request.
REQ-028 annul_i is ignored in END.
REQ-029 A new request SHALL be accepted no earlier than the edge after END exits (no back-to-back accept in the exit cycle).
REQ-030 When not in END: ready_o=0, div_zero_o=0 and result_o=0.
REQ-031 Signed MIN / -1 SHALL return quotient MIN and remainder 0, with no flag.
REQ-032 Signed results SHALL satisfy dividend = q*divisor + r, with |r| < |divisor| and r carrying the dividend's sign.

Reset
REQ-033 rst=1 at an edge forces FREE, ready_o=0, div_zero_o=0, result_o=0 and busy_o=0, from any state including mid-divide.
REQ-034 Internal datapath registers need no reset value.

Structure
REQ-035 The shared package SHALL hold the state encodings and the DivStart/DivStop and ResReady/ResNotReady constants.
REQ-036 One combinational sub-module, div_step (single restoring step, WIDTH-parametrised), SHALL be instantiated UNROLL times in a chain.

Verification
REQ-037 WIDTH=32, UNROLL=1, unsigned 100/7 -> q=14, r=2; ready_o 34 cycles after accept.
REQ-038 Signed 0xFFFFFFF9/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
REQ-039 5/0 -> div_zero_o=1, q=0xFFFFFFFF, r=5; ready_o 2 cycles after accept.
REQ-040 Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
REQ-041 annul_i pulsed on ON cycle 10 -> FREE next edge, ready_o stays 0; then 9/3 -> q=3, r=0. A repeat with rst mid-ON gives the same recovery.
REQ-042 WIDTH=16, UNROLL=4, 1000/33 -> q=30, r=10; ready_o 6 cycles after accept; operand inputs changed after accept do not alter the result.
